alu_74382_nibble_seq: RTL and testbench

ALU_74382_NIBBLE_SEQ -- requirements
Module: alu_74382_nibble_seq

---
 rtl/alu_74382_nibble_seq_pkg.sv | 20 ++
 rtl/alu_74382_nibble_seq.sv | 95 +++++++++
 tb/tb_alu_74382_nibble_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_74382_nibble_seq_pkg.sv
// alu_74382_nibble_seq_pkg: shared 74382 slice widths, operation encoding and sequencer state type
package alu_74382_nibble_seq_pkg;
    localparam int ORIG_OPERAND_W = 4;
    localparam int ORIG_RESULT_W  = 4;
    localparam int SELECT_W       = 3;
    typedef enum logic [SELECT_W-1:0] {
        OP_CLEAR   = 3'd0,
        OP_B_SUB_A = 3'd1,
        OP_A_SUB_B = 3'd2,
        OP_ADD     = 3'd3,
        OP_XOR     = 3'd4,
        OP_OR      = 3'd5,
        OP_AND     = 3'd6,
        OP_PRESET  = 3'd7
    } e_operation;
    typedef enum logic [1:0] {IDLE, RUN, DONE} e_seq_state;
    function automatic int nibble_count(input int width);
        return width / ORIG_OPERAND_W;
    endfunction
endpackage

// File: rtl/alu_74382_nibble_seq.sv
// alu_74382_nibble_seq: runs a WIDTH-bit operation through an external 4-bit 74382 slice, one nibble per cycle, LSB first
// Ports: in_valid/in_ready/in_op/in_a/in_b/in_cn request side; alu_* drive and read the external slice;
//        out_valid/out_ready/out_f/out_cn/out_ovr result side; clk rising edge, rst_n async active-low.
module alu_74382_nibble_seq
    import alu_74382_nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  e_operation                in_op,
    input  logic [WIDTH-1:0]          in_a,
    input  logic [WIDTH-1:0]          in_b,
    input  logic                      in_cn,
    output e_operation                alu_sel,
    output logic [ORIG_OPERAND_W-1:0] alu_a,
    output logic [ORIG_OPERAND_W-1:0] alu_b,
    output logic                      alu_cn,
    input  logic [ORIG_RESULT_W-1:0]  alu_f,
    input  logic                      alu_cn4,
    input  logic                      alu_ovr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_f,
    output logic                      out_cn,
    output logic                      out_ovr
);
    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int CNT_W   = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    generate
        if (WIDTH <= 0 || WIDTH % ORIG_OPERAND_W != 0) begin : g_bad_width
            $error("WIDTH must be a non-zero multiple of ORIG_OPERAND_W");
        end
    endgenerate

    e_seq_state       state;
    e_operation       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cn_q, ovr_q;
    logic             run;

    assign run       = state == RUN;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_f     = res_q;
    assign out_cn    = cn_q;
    assign out_ovr   = ovr_q;
    assign alu_sel   = run ? op_q : OP_CLEAR;
    assign alu_a     = run ? a_q[cnt_q*ORIG_OPERAND_W +: ORIG_OPERAND_W] : '0;
    assign alu_b     = run ? b_q[cnt_q*ORIG_OPERAND_W +: ORIG_OPERAND_W] : '0;
    assign alu_cn    = run & carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_CLEAR;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cn_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state   <= RUN;
                    op_q    <= in_op;
                    a_q     <= in_a;
                    b_q     <= in_b;
                    carry_q <= in_cn;
                    cnt_q   <= '0;
                end
                RUN: begin
                    res_q[cnt_q*ORIG_OPERAND_W +: ORIG_OPERAND_W] <= alu_f;
                    carry_q <= alu_cn4;
                    // counter parks on the last index instead of wrapping
                    cnt_q   <= cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state <= DONE;
                        cn_q  <= alu_cn4;
                        ovr_q <= alu_ovr;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_74382_nibble_seq.sv
// tb_alu_74382_nibble_seq: sequencer plus 74382 slice model checked against wide-arithmetic reference
module tb_alu_74382_nibble_seq;
    import alu_74382_nibble_seq_pkg::*;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_cn = 1'b0;
    e_operation in_op = OP_CLEAR, alu_sel;
    logic [W-1:0] in_a = '0, in_b = '0, out_f;
    logic [3:0] alu_a, alu_b, alu_f;
    logic alu_cn, alu_cn4, alu_ovr;
    logic out_valid, out_ready = 1'b0, out_cn, out_ovr;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_74382_nibble_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cn(in_cn),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cn(alu_cn),
        .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_ovr(alu_ovr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_cn(out_cn), .out_ovr(out_ovr)
    );

    // 74382 slice: arithmetic ops produce carry and signed overflow, others report 0 for both
    logic [4:0] s;
    always_comb begin
        s = 5'd0;
        alu_ovr = 1'b0;
        case (alu_sel)
            OP_ADD:     s = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cn);
            OP_A_SUB_B: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_cn);
            OP_B_SUB_A: s = {1'b0, alu_b} + {1'b0, ~alu_a} + 5'(alu_cn);
            OP_XOR:     s = {1'b0, alu_a ^ alu_b};
            OP_OR:      s = {1'b0, alu_a | alu_b};
            OP_AND:     s = {1'b0, alu_a & alu_b};
            OP_PRESET:  s = 5'h0F;
            default:    s = 5'd0;
        endcase
        case (alu_sel)
            OP_ADD:     alu_ovr = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
            OP_A_SUB_B: alu_ovr = (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]);
            OP_B_SUB_A: alu_ovr = (alu_a[3] != alu_b[3]) && (s[3] != alu_b[3]);
            default:    alu_ovr = 1'b0;
        endcase
        alu_f   = s[3:0];
        alu_cn4 = s[4];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // returns {ovr, carry, f} from whole-word integer arithmetic
    function automatic logic [W+1:0] ref_op(input e_operation op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cn);
        int u, sv;
        logic [W-1:0] f;
        logic c, v;
        u = 0; sv = 0; f = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                u  = int'(a) + int'(b) + int'(cn);
                sv = int'($signed(a)) + int'($signed(b)) + int'(cn);
            end
            OP_A_SUB_B: begin
                u  = int'(a) + (2**W - 1 - int'(b)) + int'(cn);
                sv = int'($signed(a)) - int'($signed(b)) - (1 - int'(cn));
            end
            OP_B_SUB_A: begin
                u  = int'(b) + (2**W - 1 - int'(a)) + int'(cn);
                sv = int'($signed(b)) - int'($signed(a)) - (1 - int'(cn));
            end
            default: ;
        endcase
        if (op == OP_ADD || op == OP_A_SUB_B || op == OP_B_SUB_A) begin
            f = u[W-1:0];
            c = u >= 2**W;
            v = sv > 2**(W-1) - 1 || sv < -(2**(W-1));
        end else begin
            f = op == OP_XOR ? a ^ b : op == OP_OR ? a | b : op == OP_AND ? a & b : op == OP_PRESET ? '1 : '0;
        end
        return {v, c, f};
    endfunction

    // out_valid rises after the NIB-th edge following accept, so a consumer first samples it at edge T+NIB+1
    task automatic run_op(input string tag, input e_operation op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cn, input int hold, input bit poke);
        int t, lat;
        logic [W+1:0] exp;
        logic [W-1:0] held;
        exp = ref_op(op, a, b, cn);
        t = 0;
        while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
        check({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cn = cn;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_cn = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, NIB);
        check({tag, "_f"}, out_f, exp[W-1:0]);
        check({tag, "_cn"}, out_cn, exp[W]);
        check({tag, "_ovr"}, out_ovr, exp[W+1]);
        held = out_f;
        if (poke) begin in_valid = 1'b1; in_op = OP_PRESET; in_a = '1; in_b = '1; end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_f"}, out_f, held);
            check({tag, "_hold_v"}, {out_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
        #1 check({tag, "_xfer_rdy"}, in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, "_after"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        bit seen;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_f", {out_f, out_cn, out_ovr}, 0);
        check("rst_alu", {alu_sel, alu_a, alu_b, alu_cn}, {OP_CLEAR, 9'd0});
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("add_carry", OP_ADD, 16'h00FF, 16'h0001, 1'b0, 0, 0);
        run_op("sub_borrow", OP_A_SUB_B, 16'h1000, 16'h0001, 1'b1, 1, 0);
        run_op("add_ovr", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 0, 0);
        run_op("xor", OP_XOR, 16'hA5A5, 16'hFFFF, 1'b0, 3, 1);
        run_op("clear", OP_CLEAR, 16'h1234, 16'h5678, 1'b1, 0, 0);
        run_op("bsuba", OP_B_SUB_A, 16'h0003, 16'h8000, 1'b1, 0, 0);
        check("idle_alu", {alu_sel, alu_a, alu_b, alu_cn}, {OP_CLEAR, 9'd0});
        for (int k = 0; k < 40; k++)
            run_op("rand", e_operation'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        run_op("preset", OP_PRESET, 16'h0000, 16'h0000, 1'b0, 0, 0);
        in_valid = 1'b1; in_op = OP_ADD; in_a = 16'h0F0F; in_b = 16'h0101; in_cn = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {out_valid, in_ready}, 2'b01);
        check("arst_out", {out_f, out_cn, out_ovr}, 0);
        check("arst_alu", {alu_sel, alu_a, alu_b, alu_cn}, {OP_CLEAR, 9'd0});
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; seen |= out_valid; end
        check("arst_no_valid", seen, 0);
        run_op("post_rst", OP_ADD, 16'h0001, 16'h0001, 1'b0, 0, 0);
        check("post_rst_f", out_f, 16'h0002);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
